// File: rtl/sgdmac_desc_ctrl.sv
// Scatter-gather descriptor sequencer: walks a linked list of 4-word descriptors
// and issues one copy command per non-empty descriptor to the DMA engine.
module sgdmac_desc_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      start_pointer_i,
  output logic             done_o,
  output logic             rd_req_o,
  output logic [31:0]      rd_addr_o,
  input  logic             rd_gnt_i,
  input  logic             rd_rvalid_i,
  input  logic [31:0]      rd_rdata_i,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [31:0]      cmd_src_o,
  output logic [31:0]      cmd_dst_o,
  output logic [LEN_W-1:0] cmd_len_o,
  input  logic             eng_done_i,
  output logic [CNT_W-1:0] desc_cnt_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    CMD        = 3'd3,
    XFER_WAIT  = 3'd4,
    NEXT       = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [27:0]      base_r, base_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             word_wr_s;

  logic [31:0]      src_r, dst_r;
  logic [LEN_W-1:0] len_r;
  logic [27:0]      nxt_base_r;
  logic             eoc_r;

  logic             done_r, rd_req_r, cmd_valid_r;
  logic [31:0]      rd_addr_r;

  // Descriptors are 16-byte aligned, so the low pointer bits carry no information.
  logic unused_s;
  assign unused_s = ^start_pointer_i[3:0];

  // Next-state and datapath update decisions
  always_comb begin
    state_nxt_s = state_r;
    base_nxt_s  = base_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    word_wr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s = FETCH_REQ;
          base_nxt_s  = start_pointer_i[31:4];
          idx_nxt_s   = 2'd0;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH_REQ: begin
        if (rd_gnt_i) begin
          state_nxt_s = FETCH_WAIT;
        end else begin
          state_nxt_s = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (rd_rvalid_i) begin
          word_wr_s = 1'b1;
          if (idx_r != 2'd3) begin
            idx_nxt_s   = idx_r + 2'd1;
            state_nxt_s = FETCH_REQ;
          end else if (len_r != {LEN_W{1'b0}}) begin
            state_nxt_s = CMD;
          end else begin
            // Zero-length descriptors are skipped but still counted.
            state_nxt_s = NEXT;
          end
        end else begin
          state_nxt_s = FETCH_WAIT;
        end
      end
      CMD: begin
        if (cmd_ready_i) begin
          state_nxt_s = XFER_WAIT;
        end else begin
          state_nxt_s = CMD;
        end
      end
      XFER_WAIT: begin
        if (eng_done_i) begin
          state_nxt_s = NEXT;
        end else begin
          state_nxt_s = XFER_WAIT;
        end
      end
      NEXT: begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (eoc_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FETCH_REQ;
          base_nxt_s  = nxt_base_r;
          idx_nxt_s   = 2'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state, chain pointer and descriptor word storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= 28'h0;
      idx_r      <= 2'd0;
      cnt_r      <= {CNT_W{1'b0}};
      src_r      <= 32'h0;
      dst_r      <= 32'h0;
      len_r      <= {LEN_W{1'b0}};
      nxt_base_r <= 28'h0;
      eoc_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      base_r  <= base_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (word_wr_s) begin
        case (idx_r)
          2'd0:    src_r <= rd_rdata_i;
          2'd1:    dst_r <= rd_rdata_i;
          2'd2:    len_r <= rd_rdata_i[LEN_W-1:0];
          2'd3: begin
            nxt_base_r <= rd_rdata_i[31:4];
            eoc_r      <= rd_rdata_i[0];
          end
          default: eoc_r <= eoc_r;
        endcase
      end
    end
  end

  // Handshake outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r      <= 1'b1;
      rd_req_r    <= 1'b0;
      cmd_valid_r <= 1'b0;
      rd_addr_r   <= 32'h0;
    end else begin
      done_r      <= (state_nxt_s == IDLE);
      rd_req_r    <= (state_nxt_s == FETCH_REQ);
      cmd_valid_r <= (state_nxt_s == CMD);
      if (state_nxt_s == FETCH_REQ) begin
        rd_addr_r <= {base_nxt_s, idx_nxt_s, 2'b00};
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  assign done_o      = done_r;
  assign rd_req_o    = rd_req_r;
  assign rd_addr_o   = rd_addr_r;
  assign cmd_valid_o = cmd_valid_r;
  assign cmd_src_o   = src_r;
  assign cmd_dst_o   = dst_r;
  assign cmd_len_o   = len_r;
  assign desc_cnt_o  = cnt_r;

endmodule

// File: doc/sgdmac_desc_ctrl.md
Name: sgdmac_desc_ctrl

Overview:
Scatter-gather descriptor sequencer for the SGDMAC.
- Takes the start pulse and descriptor start pointer from the APB config block.
- Fetches each 4-word descriptor over a single-outstanding memory read port and issues one transfer command per descriptor to the DMA copy engine.
- Follows the chain until the end-of-chain flag is seen, then reports done back to the config block's status register.

Parameters:
LEN_W, 16, width of transfer byte length taken from descriptor word2[LEN_W-1:0]
CNT_W, 8, width of the processed-descriptor counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  one-cycle start pulse from config block
start_pointer_i  input  32  address of first descriptor; bits [3:0] ignored (16-byte aligned)
done_o  output  1  1 when idle (chain complete or never started), 0 while busy
rd_req_o  output  1  memory read request valid
rd_addr_o  output  32  word address of read request
rd_gnt_i  input  1  read request accepted this cycle
rd_rvalid_i  input  1  read data valid
rd_rdata_i  input  32  read data
cmd_valid_o  output  1  transfer command valid to DMA engine
cmd_ready_i  input  1  engine accepts command
cmd_src_o  output  32  source address
cmd_dst_o  output  32  destination address
cmd_len_o  output  LEN_W  byte length, never 0 when cmd_valid_o=1
eng_done_i  input  1  one-cycle pulse: engine finished the accepted command
desc_cnt_o  output  CNT_W  descriptors completed since last start

Behaviour:
Descriptor format (16 bytes at base B = {ptr[31:4],4'h0}):
- word0 src at B.
- word1 dst at B+4.
- word2 len at B+8.
- word3 next at B+12; bit0 = end-of-chain, next base = {next[31:4],4'h0}.

Reset (rst_n=0 at posedge):
- State IDLE; done_o=1.
- rd_req_o=0, cmd_valid_o=0, rd_addr_o=0, cmd_src_o/cmd_dst_o/cmd_len_o=0, desc_cnt_o=0.
- Word index=0.
- Reset mid-operation aborts immediately; late rd_rvalid_i/eng_done_i pulses arriving in IDLE are ignored.

States: IDLE, FETCH_REQ, FETCH_WAIT, CMD, XFER_WAIT, NEXT.
- IDLE:
  - start_i=1 → latch base from start_pointer_i, desc_cnt_o←0, idx←0, done_o←0, go to FETCH_REQ.
  - done_o falls the cycle after start_i.
  - start_i in any other state is ignored.
- FETCH_REQ:
  - rd_req_o=1, rd_addr_o=base+4*idx.
  - Request and address held stable until rd_gnt_i=1; then go to FETCH_WAIT.
- FETCH_WAIT:
  - On rd_rvalid_i, store rd_rdata_i into word[idx].
  - idx<3 → idx++, go to FETCH_REQ.
  - idx==3 → go to CMD if len[LEN_W-1:0]≠0, else go to NEXT (zero-length descriptor skipped; no command issued, still counted).
  - Read latency is unbounded; there is no timeout.
  - rd_rvalid_i outside FETCH_WAIT is ignored.
- CMD:
  - cmd_valid_o=1 with src/dst/len from the fetched words.
  - cmd_* held stable until cmd_ready_i=1 (valid/ready); then go to XFER_WAIT.
- XFER_WAIT: wait for eng_done_i; then go to NEXT.
  - eng_done_i in the same cycle as the cmd_ready_i handshake is not counted; it must arrive in XFER_WAIT.
- NEXT (one cycle):
  - desc_cnt_o++ (mod 2^CNT_W).
  - next[0]=1 → go to IDLE; done_o=1 from the following cycle.
  - Otherwise base←{next[31:4],4'h0}, idx←0, go to FETCH_REQ.

Other rules:
- Only one read is outstanding at a time; rd_req_o is never asserted outside FETCH_REQ.
- cmd_valid_o is asserted only in CMD.
- Minimum latency for a one-descriptor chain with zero-wait gnt/rvalid/ready/done is 4×2 fetch cycles + 1 CMD + 1 XFER_WAIT + 1 NEXT.
- A self-looping chain (next==current base) runs indefinitely; loop detection is out of scope.

Test Plan:
- Single descriptor: ptr=0x1000 holds {0x2000, 0x3000, 0x40, 0x1}; start → reads at 0x1000/4/8/C in order; one command src=0x2000 dst=0x3000 len=0x40; after eng_done, desc_cnt_o=1 and done_o=1.
- Chain of 3: ptr=0x100 with next=0x200 → 0x310 (base 0x310) → next 0x1; exactly 3 commands issued in order, fetch addresses 0x100.., 0x200.., 0x310..; desc_cnt_o=3 at done.
- Zero-length middle descriptor: len=0 in descriptor 2 of 3; only 2 commands issued, desc_cnt_o=3, done_o=1.
- Backpressure: rd_gnt_i low 5 cycles, rd_rvalid_i delayed 7 cycles, cmd_ready_i low 4 cycles → rd_addr_o/cmd_* stable throughout, no duplicate reads or commands.
- start_i pulse while in XFER_WAIT with a different pointer → ignored; chain completes from the original pointer; a later start from IDLE restarts with desc_cnt_o=0.
- rst_n low for 1 cycle during CMD → next cycle done_o=1, cmd_valid_o=0, rd_req_o=0, desc_cnt_o=0; a spurious eng_done_i afterwards causes no state change.
